checkout_sequencer: RTL



---
 rtl/checkout_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/checkout_sequencer.sv
// Checkout sequencer: walks basket slots, multiplies quantity by unit price
// with a shift-add multiplier, streams one line per slot and sums the total.
//
// Ports:
//   CLK, RESET_N                   clock, async active-low reset
//   START, ABORT                   one-cycle begin / cancel requests
//   NUM                            number of valid basket entries (clamped)
//   ENTRY_IDX -> ENTRY_ID/QTT/PRICE basket read mux (combinational return)
//   LINE_VALID/READY + LINE_*      per-slot line record handshake
//   GRAND_TOTAL, OVF               running sum, sticky saturation flag
//   BUSY, DONE                     not-idle level, completion pulse
module checkout_sequencer #(
    parameter int MAX_ENTRIES = 12,
    parameter int PRICE_W     = 16,
    parameter int QTT_W       = 4,
    parameter int TOTAL_W     = 24
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     START,
    input  logic                     ABORT,
    input  logic [3:0]               NUM,
    output logic [3:0]               ENTRY_IDX,
    input  logic [3:0]               ENTRY_ID,
    input  logic [QTT_W-1:0]         ENTRY_QTT,
    input  logic [PRICE_W-1:0]       ENTRY_PRICE,
    output logic                     LINE_VALID,
    input  logic                     LINE_READY,
    output logic [3:0]               LINE_IDX,
    output logic [3:0]               LINE_ID,
    output logic [QTT_W-1:0]         LINE_QTT,
    output logic [PRICE_W+QTT_W-1:0] LINE_TOTAL,
    output logic [TOTAL_W-1:0]       GRAND_TOTAL,
    output logic                     OVF,
    output logic                     BUSY,
    output logic                     DONE
);

    localparam int LW = PRICE_W + QTT_W;
    localparam int SW = TOTAL_W + 1;
    localparam int KW = (QTT_W > 1) ? $clog2(QTT_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MUL,
        OUT,
        FIN
    } state_t;

    state_t state, state_nx;

    logic [3:0]         n_r;
    logic [3:0]         i_r;
    logic [3:0]         entry_idx_r;
    logic [KW-1:0]      k_r;
    logic [3:0]         id_r;
    logic [QTT_W-1:0]   qtt_r;
    logic [LW-1:0]      mcand_r;
    logic [LW-1:0]      acc_r;
    logic [TOTAL_W-1:0] gt_r;
    logic               ovf_r;

    logic [3:0]         num_c;
    logic               start_ok;
    logic               abort_ok;
    logic               last_k;
    logic               last_i;
    logic [SW-1:0]      sum;

    assign num_c    = (NUM > 4'(MAX_ENTRIES)) ? 4'(MAX_ENTRIES) : NUM;
    assign start_ok = START && !ABORT;
    assign abort_ok = ABORT && (state != IDLE);
    assign last_k   = (k_r == KW'(QTT_W - 1));
    assign last_i   = (i_r == n_r - 4'd1);
    // One extra bit catches the carry out for saturation.
    assign sum      = {1'b0, gt_r} + SW'(acc_r);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (abort_ok) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        state_nx = (num_c == 4'd0) ? FIN : FETCH;
                    end
                end
                FETCH: state_nx = MUL;
                MUL: begin
                    if (last_k) begin
                        state_nx = OUT;
                    end
                end
                OUT: begin
                    if (LINE_READY) begin
                        state_nx = last_i ? FIN : FETCH;
                    end
                end
                FIN: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            n_r         <= '0;
            i_r         <= '0;
            entry_idx_r <= '0;
            k_r         <= '0;
            id_r        <= '0;
            qtt_r       <= '0;
            mcand_r     <= '0;
            acc_r       <= '0;
            gt_r        <= '0;
            ovf_r       <= 1'b0;
        end else if (abort_ok) begin
            gt_r  <= '0;
            ovf_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        n_r         <= num_c;
                        i_r         <= '0;
                        entry_idx_r <= '0;
                        gt_r        <= '0;
                        ovf_r       <= 1'b0;
                    end
                end
                FETCH: begin
                    id_r    <= ENTRY_ID;
                    qtt_r   <= ENTRY_QTT;
                    mcand_r <= LW'(ENTRY_PRICE);
                    acc_r   <= '0;
                    k_r     <= '0;
                end
                MUL: begin
                    // mcand_r tracks PRICE<<k, so no barrel shifter.
                    if (qtt_r[k_r]) begin
                        acc_r <= acc_r + mcand_r;
                    end
                    mcand_r <= mcand_r << 1;
                    k_r     <= k_r + KW'(1);
                end
                OUT: begin
                    if (LINE_READY) begin
                        if (sum[TOTAL_W]) begin
                            gt_r  <= '1;
                            ovf_r <= 1'b1;
                        end else begin
                            gt_r <= sum[TOTAL_W-1:0];
                        end
                        if (!last_i) begin
                            i_r         <= i_r + 4'd1;
                            entry_idx_r <= i_r + 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ENTRY_IDX   = entry_idx_r;
    assign LINE_VALID  = (state == OUT);
    assign LINE_IDX    = i_r;
    assign LINE_ID     = id_r;
    assign LINE_QTT    = qtt_r;
    assign LINE_TOTAL  = acc_r;
    assign GRAND_TOTAL = gt_r;
    assign OVF         = ovf_r;
    assign BUSY        = (state != IDLE);
    assign DONE        = (state == FIN);

endmodule
